// File: rtl/plc_pkg.sv
// Shared types for the parity-list scrubber: scrub FSM states and the stored {addr,way} entry.
// Entry fields use the widest supported address/way; narrower instances zero-extend into them.
package plc_pkg;

    localparam int PLC_ADDR_MAX = 32;
    localparam int PLC_WAY_MAX  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK
    } scrub_state_t;

    typedef struct packed {
        logic [PLC_ADDR_MAX-1:0] addr;
        logic [PLC_WAY_MAX-1:0]  way;
    } entry_t;

endpackage

// File: rtl/plc_list_store.sv
// Compacted, insertion-ordered list of suspect {addr,way} entries with same-cycle
// removal (write hit and/or scrub error) applied before any append.
module plc_list_store
    import plc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       add_req,
    input  logic                       wr_req,
    input  entry_t                     in_entry,
    input  logic                       rm_req,
    input  logic [$clog2(DEPTH)-1:0]   rm_idx,
    input  entry_t                     tgt_entry,
    output entry_t [DEPTH-1:0]         list,
    output logic [$clog2(DEPTH):0]     size,
    output logic [$clog2(DEPTH):0]     nxt_size,
    output logic [DEPTH-1:0]           rm_mask,
    output logic                       tgt_hit,
    output logic [$clog2(DEPTH)-1:0]   tgt_idx,
    output logic                       add_dropped
);

    localparam int IW = $clog2(DEPTH);

    entry_t [DEPTH-1:0] nxt_list;
    logic [IW:0]        fill;
    logic               dup;
    logic               add_ok;
    logic               drop;

    always_comb begin
        rm_mask = '0;
        tgt_hit = 1'b0;
        tgt_idx = '0;
        dup     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(size)) begin
                if ((wr_req && list[i] == in_entry) || (rm_req && rm_idx == IW'(i)))
                    rm_mask[i] = 1'b1;
                if (!tgt_hit && list[i] == tgt_entry) begin
                    tgt_hit = 1'b1;
                    tgt_idx = IW'(i);
                end
            end
        end
        // Only survivors count as duplicates, so an entry being removed may be re-appended.
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(size) && !rm_mask[i] && list[i] == in_entry)
                dup = 1'b1;
        end
    end

    always_comb begin
        nxt_list = list;
        fill     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(size) && !rm_mask[i]) begin
                nxt_list[fill[IW-1:0]] = list[i];
                fill = fill + (IW+1)'(1);
            end
        end
        add_ok = add_req && !wr_req && !dup && (int'(fill) < DEPTH);
        drop   = add_req && !wr_req && !dup && (int'(fill) == DEPTH);
        if (add_ok) begin
            nxt_list[fill[IW-1:0]] = in_entry;
            fill = fill + (IW+1)'(1);
        end
    end

    assign nxt_size = fill;

    always_ff @(posedge clk) begin
        list <= nxt_list;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size        <= '0;
            add_dropped <= 1'b0;
        end else begin
            size        <= nxt_size;
            add_dropped <= drop;
        end
    end

endmodule

// File: rtl/plc_list_scrubber.sv
// Periodically re-reads listed lines, reports and drops entries whose read returns a
// parity error, and keeps the scrub pointer aligned as the list compacts.
module plc_list_scrubber
    import plc_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int WAY_WIDTH      = 4,
    parameter int DEPTH          = 8,
    parameter int SCRUB_INTERVAL = 16,
    parameter int READ_LATENCY   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      add_to_list,
    input  logic [ADDR_WIDTH-1:0]     addr_in,
    input  logic [WAY_WIDTH-1:0]      way_in,
    input  logic                      write_enable,
    input  logic                      parity_err,
    output logic                      read_enable_out,
    output logic [ADDR_WIDTH-1:0]     addr_out,
    output logic [WAY_WIDTH-1:0]      way_out,
    output logic                      plc_error_found,
    output logic [ADDR_WIDTH-1:0]     err_addr,
    output logic [WAY_WIDTH-1:0]      err_way,
    output logic [$clog2(DEPTH):0]    list_size,
    output logic                      list_full,
    output logic                      add_dropped
);

    localparam int IW        = $clog2(DEPTH);
    localparam int SW        = IW + 1;
    localparam int CW        = $clog2(SCRUB_INTERVAL + 1);
    localparam int LW        = $clog2(READ_LATENCY + 1);
    localparam int WAIT_LAST = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

    scrub_state_t       state, nxt_state;
    logic [CW-1:0]      icnt;
    logic [LW-1:0]      wcnt;
    logic [IW-1:0]      ptr, ptr_nxt;
    logic [SW-1:0]      below, ptr_base;
    entry_t             in_entry, tgt_entry;
    entry_t [DEPTH-1:0] list;
    logic [SW-1:0]      nxt_size;
    logic [DEPTH-1:0]   rm_mask;
    logic               tgt_hit;
    logic [IW-1:0]      tgt_idx;
    logic               wr_tgt, err_fire, advance;

    assign in_entry.addr  = PLC_ADDR_MAX'(addr_in);
    assign in_entry.way   = PLC_WAY_MAX'(way_in);
    assign tgt_entry.addr = PLC_ADDR_MAX'(addr_out);
    assign tgt_entry.way  = PLC_WAY_MAX'(way_out);

    // A target that vanished (or is written this cycle) invalidates the read result.
    assign wr_tgt   = write_enable && (in_entry == tgt_entry);
    assign err_fire = (state == CHECK) && parity_err && tgt_hit && !wr_tgt;
    assign advance  = (state == CHECK) && !parity_err;

    plc_list_store #(
        .DEPTH(DEPTH)
    ) u_store (
        .clk        (clk),
        .rst_n      (rst_n),
        .add_req    (add_to_list),
        .wr_req     (write_enable),
        .in_entry   (in_entry),
        .rm_req     (err_fire),
        .rm_idx     (tgt_idx),
        .tgt_entry  (tgt_entry),
        .list       (list),
        .size       (list_size),
        .nxt_size   (nxt_size),
        .rm_mask    (rm_mask),
        .tgt_hit    (tgt_hit),
        .tgt_idx    (tgt_idx),
        .add_dropped(add_dropped)
    );

    assign read_enable_out = (state == ISSUE);
    assign list_full       = (list_size == SW'(DEPTH));

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (list_size != '0 && int'(icnt) == SCRUB_INTERVAL - 1) nxt_state = ISSUE;
            ISSUE:   nxt_state = (READ_LATENCY == 1) ? CHECK : WAIT;
            WAIT:    if (int'(wcnt) == WAIT_LAST) nxt_state = CHECK;
            CHECK:   nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        below = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(ptr) && rm_mask[i]) below = below + SW'(1);
        end
        ptr_base = SW'(ptr) - below;
        if (advance) ptr_base = ptr_base + SW'(1);
        ptr_nxt = (ptr_base >= nxt_size) ? '0 : ptr_base[IW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt            <= '0;
            wcnt            <= '0;
            ptr             <= '0;
            addr_out        <= '0;
            way_out         <= '0;
            plc_error_found <= 1'b0;
            err_addr        <= '0;
            err_way         <= '0;
        end else begin
            if (state == IDLE && list_size != '0 && nxt_state == IDLE) icnt <= icnt + CW'(1);
            else                                                       icnt <= '0;
            if (state == WAIT) wcnt <= wcnt + LW'(1);
            else               wcnt <= '0;
            ptr <= ptr_nxt;
            if (state == IDLE && nxt_state == ISSUE) begin
                addr_out <= ADDR_WIDTH'(list[ptr].addr);
                way_out  <= WAY_WIDTH'(list[ptr].way);
            end
            plc_error_found <= err_fire;
            if (err_fire) begin
                err_addr <= addr_out;
                err_way  <= way_out;
            end
        end
    end

endmodule

// File: doc/plc_list_scrubber.md
PLC_LIST_SCRUBBER -- requirements
Module: plc_list_scrubber

Interface
REQ-001 SHALL expose parameter ADDR_WIDTH, default 8, line address width.
REQ-002 SHALL expose parameter WAY_WIDTH, default 4, way index width.
REQ-003 SHALL expose parameter DEPTH, default 8, list entry count (power of 2, >=2).
REQ-004 SHALL expose parameter SCRUB_INTERVAL, default 16, idle cycles between scrub reads (>=1).
REQ-005 SHALL expose parameter READ_LATENCY, default 2, cycles from read_enable_out to valid parity_err (>=1).
REQ-006 SHALL have ports: clk  in  1  single clock, all logic on rising edge; rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: add_to_list  in  1  request to append {addr_in,way_in}; addr_in  in  ADDR_WIDTH  line address; way_in  in  WAY_WIDTH  way.
REQ-008 SHALL have ports: write_enable  in  1  write to {addr_in,way_in}, clears any matching entry; parity_err  in  1  parity result of scrub read.
REQ-009 SHALL have ports: read_enable_out  out  1  scrub read strobe; addr_out  out  ADDR_WIDTH  scrub address; way_out  out  WAY_WIDTH  scrub way.
REQ-010 SHALL have ports: plc_error_found  out  1  one-cycle error pulse; err_addr  out  ADDR_WIDTH, err_way  out  WAY_WIDTH  last failing entry; list_size  out  $clog2(DEPTH)+1  valid entries; list_full  out  1; add_dropped  out  1  one-cycle overflow pulse.

Function
REQ-011 List SHALL be compacted: entries 0..list_size-1 valid, in insertion order.
REQ-012 add_to_list with list not full and no duplicate SHALL write entry at index list_size, size+1, visible next cycle.
REQ-013 add_to_list matching an existing entry SHALL be ignored (no change, no add_dropped).
REQ-014 add_to_list when full (after same-cycle removals) SHALL drop the request and pulse add_dropped.
REQ-015 write_enable matching an entry SHALL remove it, shifting higher entries down one, size-1.
REQ-016 add_to_list and write_enable together for the same {addr,way} SHALL leave it absent (write wins).
REQ-017 Same-cycle removal (write or scrub error) and add SHALL apply removal first, so add succeeds on a full list.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, CHECK.
REQ-019 IDLE SHALL count SCRUB_INTERVAL cycles then go to ISSUE if list_size>0; with size 0 the counter holds at 0.
REQ-020 ISSUE SHALL assert read_enable_out for exactly one cycle with addr_out/way_out = list[ptr], then go to WAIT.
REQ-021 WAIT SHALL last READ_LATENCY-1 cycles; CHECK SHALL sample parity_err exactly READ_LATENCY cycles after the strobe.
REQ-022 CHECK with parity_err=1 and target still present SHALL pulse plc_error_found, latch err_addr/err_way, remove the entry; ptr unchanged.
REQ-023 CHECK with parity_err=0 SHALL advance ptr, wrapping to 0 at list_size; then return to IDLE.
REQ-024 If the target entry is removed by write_enable during WAIT/CHECK, the result SHALL be discarded (no pulse, no removal).
REQ-025 A removal at an index below ptr SHALL decrement ptr; ptr>=list_size after any change SHALL become 0.
REQ-026 addr_out/way_out SHALL hold last issued value when read_enable_out is low.
REQ-027 err_addr/err_way SHALL be sticky until the next reported error.

Reset
REQ-028 rst_n low SHALL asynchronously clear: list_size, ptr, interval counter, state=IDLE, all outputs 0.
REQ-029 Reset asserted mid-scrub SHALL abandon the read; no error pulse after release.

Structure
REQ-030 FSM state enum and the {addr,way} entry typedef SHALL reside in shared package plc_pkg.
REQ-031 List storage, match, and compaction SHALL be sub-module plc_list_store; FSM and pointer stay in the top.

Verification
REQ-032 Add 12/34, AA/55 -> list_size=2; after 16 idle cycles read_enable_out=1 with addr_out=12, way_out=4.
REQ-033 Fill 8 entries, add 9th -> add_dropped pulses once, list_full=1, list_size=8.
REQ-034 List {12/34,AA/55}, write_enable AA/55 -> list_size=1, next scrubs cycle 12/34 only.
REQ-035 Scrub 12/34, parity_err=1 two cycles after strobe -> plc_error_found one cycle, err_addr=12, err_way=4, size-1.
REQ-036 Scrub issued on AA/55, write_enable AA/55 during WAIT, parity_err=1 -> no error pulse, size-1 once.
REQ-037 Pull rst_n low during WAIT -> outputs 0 immediately, list_size=0, no pulse after release.
